ntt_loop_sequencer: RTL and testbench
=====================================

// Module: ntt_loop_sequencer
// PURPOSE
// - Initiator-side loop controller that drives the register address unit's control inputs
//   (set_idx, inc_idx, inc_j, sl_m, sl_j2) through a full NTT/INTT butterfly schedule.
// - Issues one butterfly request per (stage, group, butterfly) to the vector datapath
//   via a valid/ready handshake; index pulses are timed so each butterfly consumes the
//   current idx0/idx1 before they advance.
// - Software preloads m/j2/j/mode through ISPRs before start.
// PARAMETERS
// - LOG_N  8  log2 of polynomial length N (N = 2**LOG_N); stages = LOG_N, butterflies/stage = N/2
// PORTS
// - clk_i        in   1       clock
// - rst_ni       in   1       reset, asynchronous, active-low
// - start_i      in   1       start pulse; sampled only in IDLE
// - inverse_i    in   1       0 = forward (CT) schedule, 1 = inverse (GS) schedule; latched at start
// - abort_i      in   1       synchronous abort; returns to IDLE from any state
// - bf_valid_o   out  1       butterfly request; current idx0/idx1 are valid operands
// - bf_ready_i   in   1       datapath accepts butterfly when bf_valid_o & bf_ready_i
// - set_idx_o    out  1       one-cycle pulse: load idx0/idx1 from bitrev(j), bitrev(j)+m
// - inc_idx_o    out  1       one-cycle pulse: increment idx0/idx1
// - inc_j_o      out  1       one-cycle pulse: increment j (twiddle index)
// - sl_m_o       out  1       one-cycle pulse: shift m for next stage
// - sl_j2_o      out  1       one-cycle pulse: shift j2 for next stage
// - busy_o       out  1       high in every state except IDLE
// - done_o       out  1       one-cycle pulse on schedule completion
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; counters 0; inverse latch 0.
// - Counters (LOG_N bits each): bf_cnt, grp_cnt, grp_total, bf_total; stage_cnt ($clog2(LOG_N+1) bits).
// - IDLE: start_i=1 -> latch inverse_i; stage_cnt=0; forward: grp_total=1, bf_total=N/2;
//   inverse: grp_total=N/2, bf_total=1 -> SET. start_i outside IDLE is ignored.
// - SET (1 cycle): set_idx_o=1; bf_cnt=0 -> BF.
// - BF: bf_valid_o=1, held until accepted; no pulse while stalled (bf_ready_i=0).
//   On accept: inc_idx_o=1 same cycle (combinational from handshake), bf_cnt++;
//   bf_cnt==bf_total-1 -> NEXT_GRP, else stay in BF (back-to-back accepts allowed, 1 butterfly/cycle).
// - NEXT_GRP (1 cycle): inc_j_o=1; grp_cnt==grp_total-1 -> grp_cnt=0, NEXT_STG; else grp_cnt++, SET.
// - NEXT_STG (1 cycle): sl_m_o=1 and sl_j2_o=1 (also on final stage); stage_cnt==LOG_N-1 -> DONE;
//   else stage_cnt++; forward: grp_total<<=1, bf_total>>=1; inverse: grp_total>>=1, bf_total<<=1 -> SET.
// - DONE (1 cycle): done_o=1 -> IDLE.
// - Invariant: grp_total*bf_total == N/2 in every stage; never 0.
// - Outputs are mutually exclusive per cycle except sl_m_o/sl_j2_o, which always pulse together.
// - abort_i: takes priority over all transitions; next cycle IDLE, no pulses emitted in abort
//   cycle, no done_o; in-flight bf_valid_o drops without accept.
// - Async reset mid-operation: immediate IDLE, outputs 0.
// - Cycle count with bf_ready_i tied 1: per stage grp_total*(bf_total+2)+1; plus 1 DONE cycle.
// TESTING
// - LOG_N=3, forward, ready=1, start -> 7 set_idx, 12 inc_idx, 7 inc_j, 3 sl_m/sl_j2,
//   done_o exactly 30 cycles after start sampled.
// - LOG_N=3, inverse, ready=1 -> stage groups 4,2,1; same pulse totals (7/12/7/3); 30 cycles.
// - LOG_N=8, forward, ready=1 -> 1024 accepted butterflies, 255 inc_j, 8 sl pulses,
//   done_o 1543 cycles after start.
// - Random bf_ready_i stalls (50%) -> bf_valid_o stable while stalled,
//   inc_idx_o count == accepted count == N/2*LOG_N.
// - abort_i in BF of stage 2 -> IDLE next cycle, busy_o=0, no done_o; fresh start completes normally.
// - start_i pulsed while busy -> ignored; rst_ni low mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/ntt_loop_sequencer.sv
// Loop sequencer that walks the register address unit through a full NTT/INTT butterfly schedule.
// One valid/ready butterfly request per (stage, group, butterfly); index pulses follow each accept.
module ntt_loop_sequencer #(
   parameter int unsigned LOG_N = 8
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic start_i,
   input  logic inverse_i,
   input  logic abort_i,
   output logic bf_valid_o,
   input  logic bf_ready_i,
   output logic set_idx_o,
   output logic inc_idx_o,
   output logic inc_j_o,
   output logic sl_m_o,
   output logic sl_j2_o,
   output logic busy_o,
   output logic done_o
);

   localparam int unsigned SW = $clog2(LOG_N + 1);
   localparam logic [LOG_N-1:0] ONE      = LOG_N'(1);
   localparam logic [LOG_N-1:0] HALF     = ONE << (LOG_N - 1);
   localparam logic [SW-1:0]    LAST_STG = SW'(LOG_N - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SET,
      S_BF,
      S_NEXT_GRP,
      S_NEXT_STG,
      S_DONE
   } state_e;

   state_e state_q, state_d;

   logic             inv_q;
   logic [LOG_N-1:0] bf_cnt_q;
   logic [LOG_N-1:0] grp_cnt_q;
   logic [LOG_N-1:0] grp_total_q;
   logic [LOG_N-1:0] bf_total_q;
   logic [SW-1:0]    stage_cnt_q;

   logic accept;
   logic last_bf;
   logic last_grp;
   logic last_stg;

   always_comb begin
      accept   = (state_q == S_BF) && bf_ready_i && !abort_i;
      last_bf  = (bf_cnt_q == bf_total_q - ONE);
      last_grp = (grp_cnt_q == grp_total_q - ONE);
      last_stg = (stage_cnt_q == LAST_STG);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:     if (start_i) state_d = S_SET;
         S_SET:      state_d = S_BF;
         S_BF:       if (accept && last_bf) state_d = S_NEXT_GRP;
         S_NEXT_GRP: state_d = last_grp ? S_NEXT_STG : S_SET;
         S_NEXT_STG: state_d = last_stg ? S_DONE : S_SET;
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
      if (abort_i) state_d = S_IDLE;
   end

   // Pulses are gated by abort so the abort cycle is silent and no butterfly can be accepted in it.
   always_comb begin
      bf_valid_o = (state_q == S_BF) && !abort_i;
      inc_idx_o  = accept;
      set_idx_o  = (state_q == S_SET) && !abort_i;
      inc_j_o    = (state_q == S_NEXT_GRP) && !abort_i;
      sl_m_o     = (state_q == S_NEXT_STG) && !abort_i;
      sl_j2_o    = (state_q == S_NEXT_STG) && !abort_i;
      done_o     = (state_q == S_DONE) && !abort_i;
      busy_o     = (state_q != S_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         inv_q       <= 1'b0;
         bf_cnt_q    <= '0;
         grp_cnt_q   <= '0;
         grp_total_q <= '0;
         bf_total_q  <= '0;
         stage_cnt_q <= '0;
      end else if (!abort_i) begin
         unique case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  inv_q       <= inverse_i;
                  stage_cnt_q <= '0;
                  grp_cnt_q   <= '0;
                  grp_total_q <= inverse_i ? HALF : ONE;
                  bf_total_q  <= inverse_i ? ONE : HALF;
               end
            end
            S_SET: bf_cnt_q <= '0;
            S_BF: begin
               if (accept) bf_cnt_q <= bf_cnt_q + ONE;
            end
            S_NEXT_GRP: grp_cnt_q <= last_grp ? '0 : grp_cnt_q + ONE;
            S_NEXT_STG: begin
               // Forward widens groups and narrows butterflies per stage; inverse does the opposite.
               if (!last_stg) begin
                  stage_cnt_q <= stage_cnt_q + SW'(1);
                  if (inv_q) begin
                     grp_total_q <= grp_total_q >> 1;
                     bf_total_q  <= bf_total_q << 1;
                  end else begin
                     grp_total_q <= grp_total_q << 1;
                     bf_total_q  <= bf_total_q >> 1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   a_work_conserved: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state_q != S_IDLE) |->
         ((2*LOG_N)'(grp_total_q) * (2*LOG_N)'(bf_total_q) == (2*LOG_N)'(HALF)));

   a_pulse_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0({set_idx_o, inc_idx_o, inc_j_o, sl_m_o, done_o}) && (sl_m_o == sl_j2_o));

endmodule

// File: tb/tb_ntt_loop_sequencer.sv
// Scoreboard bench: the expected pulse schedule is queued at start and popped on every DUT pulse.
module tb_ntt_loop_sequencer;

   localparam logic [5:0] EV_SET  = 6'b100000;
   localparam logic [5:0] EV_INC  = 6'b010000;
   localparam logic [5:0] EV_J    = 6'b001000;
   localparam logic [5:0] EV_SL   = 6'b000110;
   localparam logic [5:0] EV_DONE = 6'b000001;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   logic start3 = 1'b0, start8 = 1'b0, inverse = 1'b0, abort = 1'b0, ready = 1'b1;
   logic v3, set3, inc3, j3, slm3, slj3, busy3, done3;
   logic v8, set8, inc8, j8, slm8, slj8, busy8, done8;

   always #5 clk_i = ~clk_i;

   ntt_loop_sequencer #(.LOG_N(3)) u_dut3 (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start3), .inverse_i(inverse), .abort_i(abort),
      .bf_valid_o(v3), .bf_ready_i(ready), .set_idx_o(set3), .inc_idx_o(inc3), .inc_j_o(j3),
      .sl_m_o(slm3), .sl_j2_o(slj3), .busy_o(busy3), .done_o(done3)
   );

   ntt_loop_sequencer #(.LOG_N(8)) u_dut8 (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start8), .inverse_i(inverse), .abort_i(abort),
      .bf_valid_o(v8), .bf_ready_i(ready), .set_idx_o(set8), .inc_idx_o(inc8), .inc_j_o(j8),
      .sl_m_o(slm8), .sl_j2_o(slj8), .busy_o(busy8), .done_o(done8)
   );

   logic       sel8 = 1'b0;
   logic       rnd_ready = 1'b0;
   logic [5:0] pulses;
   logic       valid_m, busy_m;
   logic [7:0] all3, all8;

   assign pulses  = sel8 ? {set8, inc8, j8, slm8, slj8, done8} : {set3, inc3, j3, slm3, slj3, done3};
   assign valid_m = sel8 ? v8 : v3;
   assign busy_m  = sel8 ? busy8 : busy3;
   assign all3    = {v3, set3, inc3, j3, slm3, slj3, busy3, done3};
   assign all8    = {v8, set8, inc8, j8, slm8, slj8, busy8, done8};

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [5:0] exp_q[$];
   logic       mon_en = 1'b0;
   logic       prev_stall = 1'b0;
   int cyc, done_cyc, n_set, n_inc, n_j, n_sl, n_done, n_acc;

   always @(posedge clk_i) begin
      #1 ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   always @(negedge clk_i) begin
      if (mon_en) begin
         cyc++;
         if (abort) begin
            chk("abort_quiet", {26'b0, pulses}, 32'd0);
         end else begin
            if (prev_stall) chk("valid_held", {31'b0, valid_m}, 32'd1);
            if (pulses != 6'b0) begin
               if (exp_q.size() == 0) chk("extra_pulse", {26'b0, pulses}, 32'd0);
               else chk("pulse_seq", {26'b0, pulses}, {26'b0, exp_q.pop_front()});
               if (pulses[4]) chk("inc_hs", {30'b0, valid_m, ready}, 32'd3);
            end
            if (valid_m && ready) n_acc++;
         end
         prev_stall = valid_m & ~ready & ~abort;
         if (pulses[5]) n_set++;
         if (pulses[4]) n_inc++;
         if (pulses[3]) n_j++;
         if (pulses[2]) n_sl++;
         if (pulses[0]) begin
            n_done++;
            done_cyc = cyc;
         end
      end
   end

   task automatic push_schedule(input int log_n, input bit inv);
      int half = 1 << (log_n - 1);
      exp_q.delete();
      for (int s = 0; s < log_n; s++) begin
         int groups = inv ? (half >> s) : (1 << s);
         int bfs = half / groups;
         for (int g = 0; g < groups; g++) begin
            exp_q.push_back(EV_SET);
            for (int b = 0; b < bfs; b++) exp_q.push_back(EV_INC);
            exp_q.push_back(EV_J);
         end
         exp_q.push_back(EV_SL);
      end
      exp_q.push_back(EV_DONE);
   endtask

   task automatic kick(input bit use8, input bit inv);
      cyc = 0; done_cyc = 0; n_set = 0; n_inc = 0; n_j = 0; n_sl = 0; n_done = 0; n_acc = 0;
      prev_stall = 1'b0;
      @(posedge clk_i); #1;
      sel8 = use8;
      inverse = inv;
      if (use8) start8 = 1'b1; else start3 = 1'b1;
      @(posedge clk_i);
      cyc = 0;
      mon_en = 1'b1;
      #1;
      start3 = 1'b0;
      start8 = 1'b0;
   endtask

   task automatic run_sched(input bit use8, input bit inv, input bit rnd, input int exp_cyc, input bit stray);
      int log_n = use8 ? 8 : 3;
      int half = 1 << (log_n - 1);
      int budget = use8 ? 6000 : 600;
      rnd_ready = rnd;
      push_schedule(log_n, inv);
      kick(use8, inv);
      for (int i = 0; i < budget && n_done == 0; i++) begin
         @(posedge clk_i); #1;
         if (stray && i == 5) begin
            if (use8) start8 = 1'b1; else start3 = 1'b1;
            inverse = ~inv;
         end else if (stray && i == 6) begin
            start3 = 1'b0;
            start8 = 1'b0;
            inverse = inv;
         end
      end
      chk("done_seen", n_done, 32'd1);
      @(posedge clk_i); #1;
      chk("idle_after_done", {31'b0, busy_m}, 32'd0);
      repeat (3) @(posedge clk_i);
      #1;
      mon_en = 1'b0;
      rnd_ready = 1'b0;
      chk("done_once", n_done, 32'd1);
      chk("queue_empty", exp_q.size(), 32'd0);
      if (!rnd) chk("done_cycle", done_cyc, exp_cyc);
      chk("set_count", n_set, (1 << log_n) - 1);
      chk("incj_count", n_j, (1 << log_n) - 1);
      chk("inc_count", n_inc, half * log_n);
      chk("acc_vs_inc", n_acc, n_inc);
      chk("sl_count", n_sl, log_n);
   endtask

   task automatic abort_test();
      bit found = 1'b0;
      rnd_ready = 1'b0;
      push_schedule(3, 1'b0);
      kick(1'b0, 1'b0);
      for (int i = 0; i < 100 && !found; i++) begin
         @(posedge clk_i); #1;
         if (n_sl == 2 && v3) found = 1'b1;
      end
      chk("abort_reached", {31'b0, found}, 32'd1);
      abort = 1'b1;
      @(posedge clk_i); #1;
      abort = 1'b0;
      chk("abort_busy", {31'b0, busy3}, 32'd0);
      chk("abort_valid", {31'b0, v3}, 32'd0);
      repeat (40) @(posedge clk_i);
      #1;
      chk("abort_no_done", n_done, 32'd0);
      mon_en = 1'b0;
   endtask

   task automatic reset_test();
      rnd_ready = 1'b0;
      push_schedule(8, 1'b0);
      kick(1'b1, 1'b0);
      repeat (12) @(posedge clk_i);
      #1;
      mon_en = 1'b0;
      chk("busy_before_rst", {31'b0, busy8}, 32'd1);
      #2 rst_ni = 1'b0;
      #1;
      chk("rst_mid_outputs", {24'b0, all8}, 32'd0);
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      chk("rst_mid_idle", {24'b0, all8}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk_i);
      #1;
      chk("reset_out3", {24'b0, all3}, 32'd0);
      chk("reset_out8", {24'b0, all8}, 32'd0);
      rst_ni = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      chk("idle_out3", {24'b0, all3}, 32'd0);

      run_sched(1'b0, 1'b0, 1'b0, 30, 1'b0);
      run_sched(1'b0, 1'b1, 1'b0, 30, 1'b0);
      run_sched(1'b1, 1'b0, 1'b0, 1543, 1'b0);
      run_sched(1'b0, 1'b1, 1'b1, 0, 1'b0);
      run_sched(1'b1, 1'b0, 1'b1, 0, 1'b0);
      run_sched(1'b0, 1'b0, 1'b0, 30, 1'b1);
      abort_test();
      run_sched(1'b0, 1'b0, 1'b0, 30, 1'b0);
      reset_test();
      run_sched(1'b1, 1'b1, 1'b0, 1543, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
